// File: rtl/counter_mod_updown.sv
// rtl/counter_mod_updown.sv - modulo up/down event counter with load, wrap pulses, sticky flag and event count
// Optional COUNTER_MOD_SAT_EN: hold at the limits instead of wrapping.
module counter_mod_updown #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int EVW     = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             EN,
  input  logic             UP,
  input  logic             OV_ACK,
  output logic [WIDTH-1:0] counter,
  output logic             OV,
  output logic             UF,
  output logic             OV_ST,
  output logic [EVW-1:0]   EVCNT
);

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [EVW-1:0]   EV_MAX = '1;

  logic             at_max;
  logic             at_zero;
  logic             step;
  logic             up_evt;
  logic             dn_evt;
  logic             evt;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] dn_next;
  logic [WIDTH-1:0] counter_next;

  assign at_max  = (counter == MAX_W);
  assign at_zero = (counter == '0);

  // Only a plain enabled step can hit a limit; CLR and LOAD mask events.
  assign step   = !CLR && !LOAD && EN;
  assign up_evt = step && UP && at_max;
  assign dn_evt = step && !UP && at_zero;
  assign evt    = up_evt || dn_evt;

  assign load_clamped = (LOAD_VAL > MAX_W) ? MAX_W : LOAD_VAL;

`ifdef COUNTER_MOD_SAT_EN
  assign up_next = at_max  ? MAX_W : counter + WIDTH'(1);
  assign dn_next = at_zero ? '0    : counter - WIDTH'(1);
`else
  assign up_next = at_max  ? '0    : counter + WIDTH'(1);
  assign dn_next = at_zero ? MAX_W : counter - WIDTH'(1);
`endif

  always_comb begin
    counter_next = counter;
    if (CLR)       counter_next = '0;
    else if (LOAD) counter_next = load_clamped;
    else if (EN)   counter_next = UP ? up_next : dn_next;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      counter <= '0;
      OV      <= 1'b0;
      UF      <= 1'b0;
      OV_ST   <= 1'b0;
      EVCNT   <= '0;
    end else begin
      counter <= counter_next;
      OV      <= up_evt;
      UF      <= dn_evt;
      if (evt)         OV_ST <= 1'b1;
      else if (OV_ACK) OV_ST <= 1'b0;
      if (CLR)                         EVCNT <= '0;
      else if (evt && EVCNT != EV_MAX) EVCNT <= EVCNT + EVW'(1);
    end
  end

endmodule

// File: tb/tb_counter_mod_updown.sv
// tb/tb_counter_mod_updown.sv - directed vector bench for counter_mod_updown
module tb_counter_mod_updown;

`ifdef COUNTER_MOD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       ov_ack = 1'b0;

  logic [7:0] counter_a, counter_b;
  logic       ov_a, uf_a, ov_st_a, ov_b, uf_b, ov_st_b;
  logic [3:0] evcnt_a, evcnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_mod_updown #(.WIDTH(8), .MAX_VAL(9), .EVW(4)) dut_a (
    .clk(clk), .Reset(reset), .CLR(clr), .LOAD(load), .LOAD_VAL(load_val),
    .EN(en), .UP(up), .OV_ACK(ov_ack),
    .counter(counter_a), .OV(ov_a), .UF(uf_a), .OV_ST(ov_st_a), .EVCNT(evcnt_a)
  );

  counter_mod_updown #(.WIDTH(8), .MAX_VAL(1), .EVW(4)) dut_b (
    .clk(clk), .Reset(reset), .CLR(clr), .LOAD(load), .LOAD_VAL(load_val),
    .EN(en), .UP(up), .OV_ACK(ov_ack),
    .counter(counter_b), .OV(ov_b), .UF(uf_b), .OV_ST(ov_st_b), .EVCNT(evcnt_b)
  );

  typedef struct {
    string name;
    bit    clr, load;
    int    load_val;
    bit    en, up, ack;
    int    cnt;
    bit    ov, uf, st;
    int    ev;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, sample on the next falling edge.
  task automatic cycle(input bit c, input bit l, input int lv, input bit e, input bit u, input bit a);
    clr = c; load = l; load_val = 8'(lv); en = e; up = u; ov_ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_a(input string name, input int cnt, input bit ov, input bit uf, input bit st, input int ev);
    chk({name, ".counter"}, int'(counter_a), cnt);
    chk({name, ".OV"}, int'(ov_a), int'(ov));
    chk({name, ".UF"}, int'(uf_a), int'(uf));
    chk({name, ".OV_ST"}, int'(ov_st_a), int'(st));
    chk({name, ".EVCNT"}, int'(evcnt_a), ev);
  endtask

  initial begin
    int wrap_val;
    int pulses;

    wrap_val = SAT ? 9 : 0;
    //             name          clr load lv   en up ack  cnt            ov uf st ev
    vecs[0]  = '{"load8",        0, 1,   8,   0, 0, 0,   8,             0, 0, 0, 0};
    vecs[1]  = '{"up_to_max",    0, 0,   0,   1, 1, 0,   9,             0, 0, 0, 0};
    vecs[2]  = '{"up_wrap",      0, 0,   0,   1, 1, 0,   wrap_val,      1, 0, 1, 1};
    vecs[3]  = '{"hold",         0, 0,   0,   0, 1, 0,   wrap_val,      0, 0, 1, 1};
    vecs[4]  = '{"load0",        0, 1,   0,   0, 0, 0,   0,             0, 0, 1, 1};
    vecs[5]  = '{"down_wrap",    0, 0,   0,   1, 0, 0,   SAT ? 0 : 9,   0, 1, 1, 2};
    vecs[6]  = '{"load7",        0, 1,   7,   0, 0, 0,   7,             0, 0, 1, 2};
    vecs[7]  = '{"clr_prio",     1, 1,   5,   1, 1, 0,   0,             0, 0, 1, 0};
    vecs[8]  = '{"load_clamp",   0, 1,   200, 0, 0, 0,   9,             0, 0, 1, 0};
    vecs[9]  = '{"evt_and_ack",  0, 0,   0,   1, 1, 1,   wrap_val,      1, 0, 1, 1};
    vecs[10] = '{"ack_alone",    0, 0,   0,   0, 0, 1,   wrap_val,      0, 0, 0, 1};
    vecs[11] = '{"load1",        0, 1,   1,   0, 0, 0,   1,             0, 0, 0, 1};
    vecs[12] = '{"down_step",    0, 0,   0,   1, 0, 0,   0,             0, 0, 0, 1};
    vecs[13] = '{"down_limit",   0, 0,   0,   1, 0, 0,   SAT ? 0 : 9,   0, 1, 1, 2};

    @(negedge clk);
    reset = 1'b1;
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    chk_a("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (3) cycle(0, 0, 0, 1, 1, 0);
    chk("count3.counter", int'(counter_a), 3);

    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].up, vecs[i].ack);
      chk_a(vecs[i].name, vecs[i].cnt, vecs[i].ov, vecs[i].uf, vecs[i].st, vecs[i].ev);
    end

    // Mid-count reset overrides a concurrent enable.
    cycle(0, 1, 4, 0, 0, 0);
    reset = 1'b1;
    cycle(0, 0, 0, 1, 1, 0);
    reset = 1'b0;
    chk_a("mid_reset", 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    chk("after_reset.counter", int'(counter_a), 1);

    // Event-count saturation on the modulo-2 instance.
    cycle(1, 0, 0, 0, 0, 0);
    chk("b_clr.counter", int'(counter_b), 0);
    chk("b_clr.EVCNT", int'(evcnt_b), 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 0, 1, 1, 0);
      if (ov_b) pulses++;
    end
    chk("b_sat.pulses", pulses, SAT ? 39 : 20);
    chk("b_sat.EVCNT", int'(evcnt_b), 15);
    chk("b_sat.counter", int'(counter_b), SAT ? 1 : 0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("b_hold.EVCNT", int'(evcnt_b), 15);
    chk("b_hold.OV", int'(ov_b), 0);
    chk("b_hold.OV_ST", int'(ov_st_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
